// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data extraction and
// writeback select driving the register file port, forwarding bus and retire counter.

module wb_load_align (
   input  logic [63:0] mem_data,
   input  logic [2:0]  funct3,
   input  logic [2:0]  addr_lo,
   output logic [63:0] load_data
);
   logic [63:0] sh;

   // Shift the addressed byte lane down to bit 0, then size and extend it.
   assign sh = mem_data >> {addr_lo, 3'b000};

   always_comb begin
      load_data = sh;
      case (funct3)
         3'b000:  load_data = {{56{sh[7]}},  sh[7:0]};
         3'b001:  load_data = {{48{sh[15]}}, sh[15:0]};
         3'b010:  load_data = {{32{sh[31]}}, sh[31:0]};
         3'b100:  load_data = {56'd0, sh[7:0]};
         3'b101:  load_data = {48'd0, sh[15:0]};
         3'b110:  load_data = {32'd0, sh[31:0]};
         default: load_data = sh;
      endcase
   end
endmodule

module wb_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic        in_reg_write,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  in_wb_sel,
   input  logic [2:0]  in_funct3,
   input  logic [2:0]  in_addr_lo,
   input  logic [63:0] in_alu_result,
   input  logic [63:0] in_mem_data,
   input  logic [63:0] in_pc_plus4,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [63:0] write_data,
   output logic        misaligned,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [63:0] fwd_data,
   output logic [63:0] retired_count
);
   typedef struct packed {
      logic        reg_write;
      logic [4:0]  rd;
      logic [1:0]  wb_sel;
      logic [2:0]  funct3;
      logic [2:0]  addr_lo;
      logic [63:0] alu_result;
      logic [63:0] mem_data;
      logic [63:0] pc_plus4;
   } memwb_t;

   memwb_t      q, d_in;
   logic        valid, done;
   logic        retire;
   logic        is_load;
   logic [63:0] load_data;
   logic [63:0] wb_val;

   assign d_in = '{reg_write:  in_reg_write,
                   rd:         in_rd,
                   wb_sel:     in_wb_sel,
                   funct3:     in_funct3,
                   addr_lo:    in_addr_lo,
                   alu_result: in_alu_result,
                   mem_data:   in_mem_data,
                   pc_plus4:   in_pc_plus4};

   // done marks a held instruction that has already written/retired, so a
   // stall never replays its side effects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         done  <= 1'b0;
         q     <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (stall) begin
         done  <= done | reg_write | (valid & ~done);
      end else begin
         valid <= in_valid;
         done  <= 1'b0;
         q     <= d_in;
      end
   end

   // A flushed instruction may still write this edge but does not count.
   assign retire = valid & ~done & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired_count <= 64'd0;
      else if (retire)
         retired_count <= retired_count + 64'd1;
   end

   wb_load_align u_align (
      .mem_data  (q.mem_data),
      .funct3    (q.funct3),
      .addr_lo   (q.addr_lo),
      .load_data (load_data)
   );

   assign is_load = (q.wb_sel == 2'b01);

   always_comb begin
      misaligned = 1'b0;
      if (valid && is_load) begin
         case (q.funct3[1:0])
            2'b01:   misaligned = q.addr_lo[0];
            2'b10:   misaligned = (q.addr_lo[1:0] != 2'b00);
            2'b11:   misaligned = (q.addr_lo != 3'b000);
            default: misaligned = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (q.wb_sel)
         2'b01:   wb_val = load_data;
         2'b10:   wb_val = q.pc_plus4;
         default: wb_val = q.alu_result;
      endcase
   end

   assign fwd_valid  = valid & q.reg_write & (q.rd != 5'd0) & ~misaligned;
   assign reg_write  = fwd_valid & ~done;
   assign rd         = q.rd;
   assign fwd_rd     = q.rd;
   assign write_data = wb_val;
   assign fwd_data   = wb_val;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage against a behavioural model of the writeback rules.

module tb_wb_stage;
   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid, in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3, in_addr_lo;
   logic [63:0] in_alu_result, in_mem_data, in_pc_plus4;
   logic        reg_write, misaligned, fwd_valid;
   logic [4:0]  rd, fwd_rd;
   logic [63:0] write_data, fwd_data, retired_count;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
      .reg_write(reg_write), .rd(rd), .write_data(write_data), .misaligned(misaligned),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired_count(retired_count)
   );

   typedef struct {
      bit        v, rw;
      bit [4:0]  rd;
      bit [1:0]  ws;
      bit [2:0]  f3, a;
      bit [63:0] alu, mem, pc4;
   } instr_t;

   typedef struct {
      bit        rw, mis, fv, chk_data;
      bit [4:0]  rd;
      bit [63:0] data, cnt;
   } exp_t;

   int checks = 0;
   int failures = 0;
   exp_t q[$];

   // reference state: the instruction occupying writeback and whether it already wrote
   instr_t h;
   bit     h_written;
   bit     fresh;
   bit [63:0] n_retired;

   localparam bit [63:0] MEMW = 64'h8877_6655_4433_2211;

   function automatic instr_t mk(bit v, bit rw, bit [4:0] r, bit [1:0] ws, bit [2:0] f3,
                                 bit [2:0] a, bit [63:0] alu, bit [63:0] mem, bit [63:0] pc4);
      instr_t t;
      t.v = v; t.rw = rw; t.rd = r; t.ws = ws; t.f3 = f3; t.a = a;
      t.alu = alu; t.mem = mem; t.pc4 = pc4;
      return t;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t t;
      t.v   = ($urandom_range(0, 9) != 0);
      t.rw  = ($urandom_range(0, 4) != 0);
      t.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      t.ws  = 2'($urandom);
      t.f3  = 3'($urandom);
      t.a   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      t.alu = {$urandom, $urandom};
      t.mem = {$urandom, $urandom};
      t.pc4 = {$urandom, $urandom};
      return t;
   endfunction

   // Expected outputs derived from the held instruction by plain arithmetic.
   function automatic exp_t predict();
      exp_t e;
      int   w;
      bit [63:0] val, mask;
      w = 1 << h.f3[1:0];
      e.mis = h.v && h.ws == 2'b01 && (int'(h.a) % w != 0);
      if (h.ws == 2'b01) begin
         val = h.mem >> (8 * h.a);
         if (w < 8) begin
            mask = (64'd1 << (8 * w)) - 64'd1;
            val  = val & mask;
            if (!h.f3[2] && val[8*w-1]) val = val | ~mask;
         end
      end else if (h.ws == 2'b10) val = h.pc4;
      else val = h.alu;
      e.data     = val;
      e.fv       = h.v && h.rw && h.rd != 0 && !e.mis;
      e.rw       = e.fv && !h_written;
      e.rd       = h.rd;
      e.cnt      = n_retired;
      e.chk_data = e.fv || fresh;
      return e;
   endfunction

   task automatic model_edge(bit rst, bit st, bit fl, instr_t in);
      if (rst) begin
         h = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
         h_written = 0; n_retired = 0; fresh = 1;
      end else begin
         if (h.v && !h_written && !fl) n_retired++;
         if (fl) begin
            h.v = 0; h_written = 0;
         end else if (st) begin
            if (h.v) h_written = 1;
         end else begin
            h = in; h_written = 0; fresh = 0;
         end
      end
   endtask

   task automatic step(bit rst, bit st, bit fl, instr_t in);
      @(negedge clk);
      #1;
      reset = rst; stall = st; flush = fl;
      in_valid = in.v; in_reg_write = in.rw; in_rd = in.rd; in_wb_sel = in.ws;
      in_funct3 = in.f3; in_addr_lo = in.a; in_alu_result = in.alu;
      in_mem_data = in.mem; in_pc_plus4 = in.pc4;
      @(posedge clk);
      #1;
      model_edge(rst, st, fl, in);
      q.push_back(predict());
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("reg_write", 64'(reg_write), 64'(e.rw));
         chk("misaligned", 64'(misaligned), 64'(e.mis));
         chk("fwd_valid", 64'(fwd_valid), 64'(e.fv));
         chk("retired_count", retired_count, e.cnt);
         chk("rd", 64'(rd), 64'(e.rd));
         chk("fwd_rd", 64'(fwd_rd), 64'(e.rd));
         if (e.chk_data) begin
            chk("write_data", write_data, e.data);
            chk("fwd_data", fwd_data, e.data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t idle, t;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1; stall = 0; flush = 0;
      in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0; in_funct3 = 0;
      in_addr_lo = 0; in_alu_result = 0; in_mem_data = 0; in_pc_plus4 = 0;
      step(1, 0, 0, idle);
      step(1, 0, 0, idle);
      repeat (10) step(0, 0, 0, idle);

      // ALU, loads, misaligned, rd=0, jal
      step(0, 0, 0, mk(1, 1, 5, 2'b00, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0));
      step(0, 0, 0, mk(1, 1, 3, 2'b01, 3'b000, 7, 0, MEMW, 0));
      step(0, 0, 0, mk(1, 1, 4, 2'b01, 3'b101, 6, 0, MEMW, 0));
      step(0, 0, 0, mk(1, 1, 6, 2'b01, 3'b010, 4, 0, MEMW, 0));
      step(0, 0, 0, mk(1, 1, 7, 2'b01, 3'b011, 0, 0, MEMW, 0));
      step(0, 0, 0, mk(1, 1, 9, 2'b01, 3'b010, 2, 0, MEMW, 0));
      step(0, 0, 0, mk(1, 1, 0, 2'b00, 0, 0, 64'h55, 0, 0));
      step(0, 0, 0, mk(1, 1, 1, 2'b10, 0, 0, 64'h77, 0, 64'h1004));
      step(0, 0, 0, idle);

      // stall 3 cycles on a held write, then stall+flush together
      step(0, 0, 0, mk(1, 1, 12, 2'b00, 0, 0, 64'h1234, 0, 0));
      repeat (3) step(0, 1, 0, rnd_instr());
      step(0, 0, 0, mk(1, 1, 8, 2'b00, 0, 0, 64'hABCD, 0, 0));
      step(0, 1, 1, rnd_instr());
      step(0, 0, 0, idle);

      // flush on the edge ending the write cycle
      step(0, 0, 0, mk(1, 1, 13, 2'b11, 0, 0, 64'h99, 0, 0));
      step(0, 0, 1, rnd_instr());
      step(0, 0, 0, idle);

      // reset in the middle of a stall
      step(0, 0, 0, mk(1, 1, 10, 2'b00, 0, 0, 64'hBEEF, 0, 0));
      step(0, 1, 0, rnd_instr());
      step(1, 1, 0, rnd_instr());
      step(0, 1, 0, rnd_instr());
      step(0, 0, 0, idle);

      for (int i = 0; i < 3000; i++) begin
         t = rnd_instr();
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), t);
      end
      step(0, 0, 0, idle);

      @(negedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined RISC-V core: registers the MEM/WB pipeline boundary, extracts and sign/zero-extends load data, and selects the writeback value. It drives the register file write port (reg_write, rd, write_data), the forwarding bus, and a retired-instruction counter. It is the sole writer of the register file.

## Interface
- No parameters; datapath fixed at 64 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold MEM/WB contents this edge
- flush  in  1  invalidate MEM/WB contents this edge; overrides stall
- in_valid  in  1  MEM stage holds a real instruction
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- in_funct3  in  3  load width/sign (RV64I encoding)
- in_addr_lo  in  3  low 3 bits of the load address
- in_alu_result  in  64  ALU result, signed
- in_mem_data  in  64  aligned doubleword read from data memory
- in_pc_plus4  in  64  link value
- reg_write  out  1  register file write enable
- rd  out  5  register file write address
- write_data  out  64  signed writeback value
- misaligned  out  1  held load is misaligned for its width
- fwd_valid  out  1  fwd_rd/fwd_data carry a pending write
- fwd_rd  out  5  forwarding destination
- fwd_data  out  64  forwarding value (equals write_data)
- retired_count  out  64  number of instructions retired

## Operation
- MEM/WB register: valid, reg_write, rd, wb_sel, funct3, addr_lo, alu_result, mem_data, pc_plus4; plus a done flag.
- Per edge, priority: reset > flush > stall > load. Flush: valid←0, done←0. Stall: all fields held. Load: capture inputs, valid←in_valid, done←0.
- done←1 at any edge where reg_write was high or the held instruction retired; guarantees a held instruction writes and retires exactly once under stall.
- Load extraction from mem_data, byte lane = addr_lo: funct3 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 treated as ld. Signed forms sign-extend from bit 7/15/31; unsigned forms zero-extend.
- misaligned = valid & wb_sel==01 & (h: addr_lo[0]; w: addr_lo[1:0]!=0; d: addr_lo!=0). Byte loads never misaligned.
- write_data: ALU → alu_result; load → extracted value; PC+4 → pc_plus4.
- reg_write = valid & ~done & reg_write_field & rd!=0 & ~misaligned. rd output = held rd.
- fwd_valid = valid & reg_write_field & rd!=0 & ~misaligned (stays high while stalled, even after done); fwd_rd = rd.
- retired_count increments by 1 at each edge where valid & ~done & ~flush (misaligned loads retire without writing); wraps 2^64−1 → 0.

## Timing
- Reset (async): valid=0, done=0, all fields 0; reg_write=0, rd=0, write_data=0, misaligned=0, fwd_valid=0, fwd_rd=0, fwd_data=0, retired_count=0.
- Latency: inputs captured at edge N; reg_write/write_data valid combinationally during cycle N→N+1; register file commits at edge N+1.
- Outputs are combinational from MEM/WB state only; no input→output combinational path.
- Back-to-back instructions sustain one writeback per cycle.
- Stall for k cycles: reg_write high only in the first cycle after capture; retired_count advances by 1 total.
- Flush on the edge concluding the write cycle: the write still commits at that edge (register file samples reg_write); retired_count does not advance for it.
- Stall and flush together: flush wins.
- Reset asserted mid-stall: held instruction discarded, no write after reset release.

## Test plan
- Reset then release, no valid input → all outputs 0 for 10 cycles, retired_count=0.
- ALU op rd=5, alu_result=−3, wb_sel=00 → next cycle reg_write=1, rd=5, write_data=0xFFFF_FFFF_FFFF_FFFD; retired_count=1.
- mem_data=0x8877_6655_4433_2211: lb addr_lo=7 → 0xFFFF_FFFF_FFFF_FF88; lhu addr_lo=6 → 0x8877; lw addr_lo=4 → 0xFFFF_FFFF_8877_6655; ld addr_lo=0 → full word.
- lw addr_lo=2 rd=9 → misaligned=1, reg_write=0, fwd_valid=0, retired_count+1.
- rd=0 ALU op → reg_write=0, fwd_valid=0, retired_count+1; jal wb_sel=10 pc_plus4=0x1004 rd=1 → write_data=0x1004.
- Instruction then stall 3 cycles → reg_write high exactly one cycle, fwd_valid high 4 cycles, retired_count+1; stall+flush same edge → valid=0 next cycle, no write.
